// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receive and transmit sides.
//   - rx_state_t        : receiver FSM state encoding (3 bits)
//   - *_DEFAULT         : default clock, baud and oversampling parameters
//   - calc_tick_div()   : clocks per oversample tick, truncated, never below 1
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    localparam int CLK_FREQ_DEFAULT   = 100_000_000;
    localparam int BAUD_RATE_DEFAULT  = 9_600;
    localparam int OVERSAMPLE_DEFAULT = 16;

    // Truncating divide; clamped to 1 so a too-fast baud still yields a
    // legal counter rather than a zero-length one.
    function automatic int calc_tick_div(input int clk_freq,
                                         input int baud_rate,
                                         input int oversample);
        int div;
        div = clk_freq / (baud_rate * oversample);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// ----------------------------------------------------------------------------
// baud_tick_gen
// Free-running divider producing a one-clock tick at OVERSAMPLE x BAUD_RATE.
// Shared by the UART receiver and transmitter.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous active-low reset
//   tick  out one-cycle pulse when the divider wraps
// ----------------------------------------------------------------------------
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
    parameter int BAUD_RATE  = BAUD_RATE_DEFAULT,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_wrap;

    always_comb begin
        w_wrap     = (r_cnt == CNT_MAX);
        w_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign tick = w_wrap;

endmodule

// File: rtl/uart_rx_byte.sv
// ----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART receiver. The asynchronous rx line is synchronised, then sampled
// by an FSM running on a 16x (OVERSAMPLE) baud tick. Start bit is re-checked
// at its middle to reject glitches; data bits and stop bit are sampled one
// full bit period apart from that point, i.e. near their centres.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   rx         in   asynchronous serial input, idle high
//   rx_data    out  [7:0] last good byte, held until the next good frame
//   rx_done    out  one-cycle strobe, rx_data updated this cycle
//   rx_busy    out  high while a frame is in progress (state != IDLE)
//   frame_err  out  one-cycle strobe, stop bit sampled low
// ----------------------------------------------------------------------------
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
    parameter int BAUD_RATE  = BAUD_RATE_DEFAULT,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int TCNT_W = $clog2(OVERSAMPLE);
    localparam logic [TCNT_W-1:0] TCNT_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OVERSAMPLE - 1);

    logic w_tick;

    baud_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Two-flop synchronizer; r_sync is the only version of rx used below.
    logic r_sync_meta;
    logic r_sync;

    rx_state_t         r_state,    w_state_next;
    logic [TCNT_W-1:0] r_tick_cnt, w_tick_cnt_next;
    logic [2:0]        r_bit_cnt,  w_bit_cnt_next;
    logic [7:0]        r_shift,    w_shift_next;
    logic [7:0]        r_data,     w_data_next;
    logic              r_done,     w_done_next;
    logic              r_ferr,     w_ferr_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync_meta <= 1'b1;
            r_sync      <= 1'b1;
            r_state     <= ST_IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_done      <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_sync_meta <= rx;
            r_sync      <= r_sync_meta;
            r_state     <= w_state_next;
            r_tick_cnt  <= w_tick_cnt_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_shift     <= w_shift_next;
            r_data      <= w_data_next;
            r_done      <= w_done_next;
            r_ferr      <= w_ferr_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_tick_cnt_next = r_tick_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_data_next     = r_data;
        w_done_next     = 1'b0;
        w_ferr_next     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_tick && !r_sync) begin
                    w_state_next    = ST_START;
                    w_tick_cnt_next = '0;
                end
            end

            ST_START: begin
                if (w_tick) begin
                    if (r_tick_cnt == TCNT_MID) begin
                        // Mid start bit: a line that is already high again
                        // was a glitch, so drop back without any strobe.
                        if (!r_sync) begin
                            w_state_next    = ST_DATA;
                            w_tick_cnt_next = '0;
                            w_bit_cnt_next  = '0;
                        end else begin
                            w_state_next    = ST_IDLE;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (w_tick) begin
                    if (r_tick_cnt == TCNT_LAST) begin
                        // LSB arrives first, so shift right and insert at bit 7.
                        w_shift_next    = {r_sync, r_shift[7:1]};
                        w_tick_cnt_next = '0;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_next = ST_STOP;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 1'b1;
                    end
                end
            end

            ST_STOP: begin
                if (w_tick) begin
                    if (r_tick_cnt == TCNT_LAST) begin
                        w_tick_cnt_next = '0;
                        // Leaving at mid stop bit lets an immediately
                        // following start bit be caught.
                        if (r_sync) begin
                            w_data_next  = r_shift;
                            w_done_next  = 1'b1;
                            w_state_next = ST_IDLE;
                        end else begin
                            w_ferr_next  = 1'b1;
                            w_state_next = ST_BREAK;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 1'b1;
                    end
                end
            end

            ST_BREAK: begin
                // A line held low must return high before a new start is seen.
                if (w_tick && r_sync) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign rx_data   = r_data;
    assign rx_done   = r_done;
    assign frame_err = r_ferr;
    assign rx_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
`timescale 1ns/1ps
module tb_uart_rx_byte;

    localparam int CPB = 160;   // clocks per bit: 1.6 MHz / 10 kbaud

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    uart_rx_byte #(
        .CLK_FREQ   (1_600_000),
        .BAUD_RATE  (10_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int         n_check = 0;
    int         n_pass  = 0;
    logic [7:0] got_q[$];     // bytes seen on rx_done, in order
    int         err_cnt = 0;  // frame_err pulses seen
    bit         mon_en  = 1'b0;
    logic       rst_q   = 1'b0;
    logic [7:0] prev_data;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         cpb;
        int         exp_done;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_check++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start, 8 data bits LSB first, then the stop bit; the line is
    // left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int cpb);
        rx = 1'b0;
        wait_clks(cpb);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(cpb);
        end
        rx = stop;
        wait_clks(cpb);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            rst_q = rst;
        end
    end

    // Output monitor: collects strobes and checks the strobe invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rx_done || frame_err)
                    check("strobe_exclusive", {31'b0, rx_done & frame_err}, 32'd0);
                if (rx_done) got_q.push_back(rx_data);
                if (frame_err) err_cnt++;
                if (rst_q && (rx_data !== prev_data))
                    check("data_change_needs_done", {31'b0, rx_done}, 32'd1);
            end
            prev_data = rx_data;
        end
    end

    initial begin
        int         n0;
        int         e0;
        logic [7:0] d0;
        logic [7:0] exp_q[$];
        int         exp_err;
        int         cpb_opts[3];
        logic [7:0] rb;
        logic       rs;
        int         rc;

        cpb_opts[0] = 157; cpb_opts[1] = 160; cpb_opts[2] = 163;

        //           data   stop  cpb  done err  data after
        vecs[0] = '{8'h41, 1'b1, 160, 1,   0,  8'h41};
        vecs[1] = '{8'hA5, 1'b1, 157, 1,   0,  8'hA5};
        vecs[2] = '{8'hA5, 1'b1, 163, 1,   0,  8'hA5};
        vecs[3] = '{8'h00, 1'b1, 160, 1,   0,  8'h00};
        vecs[4] = '{8'hFF, 1'b1, 160, 1,   0,  8'hFF};
        vecs[5] = '{8'h55, 1'b0, 160, 0,   1,  8'hFF};
        vecs[6] = '{8'h3C, 1'b1, 160, 1,   0,  8'h3C};

        // Reset values
        rst = 1'b0; rx = 1'b1;
        wait_clks(5);
        check("reset_rx_data",   {24'b0, rx_data}, 32'h00);
        check("reset_rx_done",   {31'b0, rx_done}, 32'd0);
        check("reset_rx_busy",   {31'b0, rx_busy}, 32'd0);
        check("reset_frame_err", {31'b0, frame_err}, 32'd0);
        rst = 1'b1;
        mon_en = 1'b1;
        wait_clks(3 * CPB);

        // Table-driven frames, including +/-2% baud and a bad stop bit
        foreach (vecs[i]) begin
            n0 = got_q.size(); e0 = err_cnt;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].cpb);
            rx = 1'b1;
            wait_clks(CPB);
            check($sformatf("vec%0d_done_count", i), got_q.size() - n0, vecs[i].exp_done);
            check($sformatf("vec%0d_err_count", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("vec%0d_rx_data", i), {24'b0, rx_data}, {24'b0, vecs[i].exp_data});
            check($sformatf("vec%0d_idle", i), {31'b0, rx_busy}, 32'd0);
        end

        // Back-to-back frames 0x30..0x3F with no idle gap
        n0 = got_q.size(); e0 = err_cnt;
        for (int b = 8'h30; b <= 8'h3F; b++) send_frame(8'(b), 1'b1, CPB);
        wait_clks(CPB);
        check("b2b_count", got_q.size() - n0, 32'd16);
        check("b2b_errs", err_cnt - e0, 32'd0);
        for (int i = 0; i < 16 && n0 + i < got_q.size(); i++)
            check($sformatf("b2b_byte%0d", i), {24'b0, got_q[n0 + i]}, 32'h30 + i);

        // Start-bit glitch of 40 clocks
        n0 = got_q.size(); e0 = err_cnt; d0 = rx_data;
        rx = 1'b0;
        wait_clks(30);
        check("glitch_busy_rises", {31'b0, rx_busy}, 32'd1);
        wait_clks(10);
        rx = 1'b1;
        wait_clks(120);
        check("glitch_busy_drops", {31'b0, rx_busy}, 32'd0);
        wait_clks(2 * CPB);
        check("glitch_no_done", got_q.size() - n0, 32'd0);
        check("glitch_no_err", err_cnt - e0, 32'd0);
        check("glitch_data_held", {24'b0, rx_data}, {24'b0, d0});

        // Bad stop bit, line held low (break), then a good frame
        n0 = got_q.size(); e0 = err_cnt; d0 = rx_data;
        send_frame(8'h55, 1'b0, CPB);
        wait_clks(2 * CPB);
        check("break_err_once", err_cnt - e0, 32'd1);
        check("break_busy", {31'b0, rx_busy}, 32'd1);
        check("break_data_held", {24'b0, rx_data}, {24'b0, d0});
        check("break_no_done", got_q.size() - n0, 32'd0);
        rx = 1'b1;
        wait_clks(CPB);
        check("break_exit_idle", {31'b0, rx_busy}, 32'd0);
        send_frame(8'h7A, 1'b1, CPB);
        wait_clks(CPB);
        check("after_break_done", got_q.size() - n0, 32'd1);
        check("after_break_data", {24'b0, rx_data}, 32'h7A);
        check("after_break_err", err_cnt - e0, 32'd1);

        // Reset pulse during bit 4 of a frame
        n0 = got_q.size(); e0 = err_cnt;
        rx = 1'b0;
        wait_clks(CPB);
        rb = 8'h96;
        for (int i = 0; i < 4; i++) begin
            rx = rb[i];
            wait_clks(CPB);
        end
        rx = rb[4];
        wait_clks(CPB / 2);
        rst = 1'b0;
        wait_clks(1);
        check("midrst_rx_data",   {24'b0, rx_data}, 32'h00);
        check("midrst_rx_done",   {31'b0, rx_done}, 32'd0);
        check("midrst_rx_busy",   {31'b0, rx_busy}, 32'd0);
        check("midrst_frame_err", {31'b0, frame_err}, 32'd0);
        rst = 1'b1;
        rx = 1'b1;
        wait_clks(2 * CPB);
        send_frame(8'hC3, 1'b1, CPB);
        wait_clks(CPB);
        check("postrst_done", got_q.size() - n0, 32'd1);
        check("postrst_data", {24'b0, rx_data}, 32'hC3);
        check("postrst_err", err_cnt - e0, 32'd0);

        // Random frames against a frame-level model: a frame with a high
        // stop bit yields its byte, a low stop bit yields one frame error.
        n0 = got_q.size(); e0 = err_cnt; exp_err = 0;
        for (int k = 0; k < 8; k++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            rc = cpb_opts[$urandom_range(0, 2)];
            if (rs) exp_q.push_back(rb);
            else    exp_err++;
            send_frame(rb, rs, rc);
            if (!rs) begin
                rx = 1'b1;
                wait_clks(CPB);
            end
        end
        wait_clks(CPB);
        check("rand_done_count", got_q.size() - n0, exp_q.size());
        check("rand_err_count", err_cnt - e0, exp_err);
        for (int i = 0; i < exp_q.size() && n0 + i < got_q.size(); i++)
            check($sformatf("rand_byte%0d", i), {24'b0, got_q[n0 + i]}, {24'b0, exp_q[i]});

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
